// File: rtl/cross_bar_arbiter_pkg.sv
// Shared constants, FSM state type and address decode helper for the 4x4 cross bar.
package mux_connection;

    localparam int QTY_OF_DEVICES = 4;
    localparam int SEL_WIDTH      = $clog2(QTY_OF_DEVICES);
    localparam int ADDR_WIDTH     = 32;

    typedef enum logic [0:0] {
        enIDLE = 1'b0,
        enBUSY = 1'b1
    } arb_state_t;

    // Target slave is carried in the most significant address bits.
    function automatic logic [SEL_WIDTH-1:0] slave_sel(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1 -: SEL_WIDTH];
    endfunction

endpackage

// File: rtl/cross_bar_arbiter_if.sv
// Request/grant bundle between the masters, the slave muxes and the arbiter.
interface cross_bar_arbiter_if;
    import mux_connection::*;

    logic [QTY_OF_DEVICES-1:0]                     master_req;
    logic [QTY_OF_DEVICES-1:0][ADDR_WIDTH-1:0]     master_addr;
    logic [QTY_OF_DEVICES-1:0]                     session_is_finished;
    logic [QTY_OF_DEVICES-1:0][QTY_OF_DEVICES-1:0] granted_matrix;
    logic [QTY_OF_DEVICES-1:0]                     slave_busy;

    // Requesting side: masters and slave muxes.
    modport master (
        output master_req,
        output master_addr,
        output session_is_finished,
        input  granted_matrix,
        input  slave_busy
    );

    // Arbiter side.
    modport slave (
        input  master_req,
        input  master_addr,
        input  session_is_finished,
        output granted_matrix,
        output slave_busy
    );

endinterface

// File: rtl/cross_bar_arbiter_rr_arbiter_slice.sv
// One slave's round-robin arbiter: IDLE/BUSY FSM, rotating priority pointer and
// a registered one-hot grant held until the slave reports its session finished.
module rr_arbiter_slice
    import mux_connection::*;
#(
    parameter  int N = QTY_OF_DEVICES,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_vec,
    input  logic         finish,
    output logic [N-1:0] grant,
    output logic         busy
);

    localparam logic [0:0] ST_IDLE = enIDLE;
    localparam logic [0:0] ST_BUSY = enBUSY;

    logic [0:0]   state;
    logic [W-1:0] ptr;
    logic [W-1:0] winner;
    logic [W-1:0] idx;
    logic         found;

    // Search starts at ptr and wraps naturally in W bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + W'(i);
            if (!found && req_vec[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: rst_n is sampled on the clock edge only; it is not in the sensitivity list.
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            // NOTE: non-blocking updates so every slice sees only pre-edge grants.
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_BUSY;
                        grant <= N'(1) << winner;
                        ptr   <= winner + W'(1);
                    end
                end
                ST_BUSY: begin
                    // Leaving BUSY never re-arbitrates on the same edge: one idle cycle.
                    if (finish) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign busy = |grant;

endmodule

// File: rtl/cross_bar_arbiter.sv
// Upstream control of the 4x4 cross bar: decodes each master's target slave and
// runs one round-robin slice per slave, producing the registered grant matrix.
module cross_bar_arbiter
    import mux_connection::*;
(
    input  logic                clk,
    input  logic                rst_n,
    cross_bar_arbiter_if.slave  bus
);

    localparam int N = QTY_OF_DEVICES;

    logic [N-1:0][N-1:0] req_vec;
    logic [N-1:0][N-1:0] grant;
    logic [N-1:0][N-1:0] grant_t;
    logic [N-1:0]        busy;
    logic [N-1:0]        owned_any;

    // Masking uses registered grants only, so there is no path from grant back to grant.
    always_comb begin
        owned_any = '0;
        grant_t   = '0;
        for (int s = 0; s < N; s++) begin
            for (int m = 0; m < N; m++) begin
                owned_any[m]  = owned_any[m] | grant[s][m];
                grant_t[m][s] = grant[s][m];
            end
        end
    end

    always_comb begin
        req_vec = '0;
        for (int s = 0; s < N; s++) begin
            for (int m = 0; m < N; m++) begin
                req_vec[s][m] = bus.master_req[m]
                             && (slave_sel(bus.master_addr[m]) == SEL_WIDTH'(s))
                             && !(owned_any[m] && !grant[s][m]);
            end
        end
    end

    for (genvar s = 0; s < N; s++) begin : g_slice
        rr_arbiter_slice #(.N(N)) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_vec (req_vec[s]),
            .finish  (bus.session_is_finished[s]),
            .grant   (grant[s]),
            .busy    (busy[s])
        );

        a_row_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant[s]));
        a_col_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_t[s]));
    end

    assign bus.granted_matrix = grant;
    assign bus.slave_busy     = busy;

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Scoreboard bench for cross_bar_arbiter: directed scenarios then random traffic,
// checked against an owner/pointer reference model of the arbitration rules.
module tb_cross_bar_arbiter;
    import mux_connection::*;

    localparam int N = QTY_OF_DEVICES;

    typedef struct packed {
        logic [N*N-1:0] gm;
        logic [N-1:0]   busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cross_bar_arbiter_if bus ();

    cross_bar_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    // Reference model: which master owns each slave (-1 = free) and the next-priority master.
    int owner[N] = '{default: -1};
    int ptr[N]   = '{default: 0};
    int nxt[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int target(input int m);
        return int'(bus.master_addr[m] >> (ADDR_WIDTH - SEL_WIDTH));
    endfunction

    function automatic bit holds(input int m);
        for (int k = 0; k < N; k++)
            if (owner[k] == m) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int s = 0; s < N; s++) begin
                owner[s] = -1;
                ptr[s]   = 0;
            end
        end else begin
            for (int s = 0; s < N; s++) nxt[s] = owner[s];
            for (int s = 0; s < N; s++) begin
                if (owner[s] >= 0) begin
                    if (bus.session_is_finished[s]) nxt[s] = -1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        int m;
                        m = (ptr[s] + i) % N;
                        if (nxt[s] < 0 && bus.master_req[m] && target(m) == s && !holds(m))
                            nxt[s] = m;
                    end
                    if (nxt[s] >= 0) ptr[s] = (nxt[s] + 1) % N;
                end
            end
            for (int s = 0; s < N; s++) owner[s] = nxt[s];
        end
        e = '0;
        for (int s = 0; s < N; s++) begin
            if (owner[s] >= 0) begin
                e.gm[s*N + owner[s]] = 1'b1;
                e.busy[s]            = 1'b1;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: every cycle the DUT presents a new registered grant matrix.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_granted_matrix", 64'(bus.granted_matrix), 64'(e.gm));
            check("sb_slave_busy", 64'(bus.slave_busy), 64'(e.busy));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [ADDR_WIDTH-1:0] addr_for(input int s);
        logic [ADDR_WIDTH-1:0] a;
        a = ADDR_WIDTH'($urandom);
        a[ADDR_WIDTH-1 -: SEL_WIDTH] = SEL_WIDTH'(s);
        return a;
    endfunction

    task automatic req(input int m, input int s);
        bus.master_req[m]  = 1'b1;
        bus.master_addr[m] = addr_for(s);
    endtask

    task automatic drop(input int m);
        bus.master_req[m] = 1'b0;
    endtask

    task automatic pulse_fin(input int s);
        bus.session_is_finished[s] = 1'b1;
        tick();
        bus.session_is_finished[s] = 1'b0;
    endtask

    task automatic expect_row(input string name, input int s, input logic [N-1:0] exp);
        check(name, 64'(bus.granted_matrix[s]), 64'(exp));
    endtask

    logic [N-1:0] t2_seq [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    initial begin
        bus.master_req          = '0;
        bus.master_addr         = '0;
        bus.session_is_finished = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("reset_matrix", 64'(bus.granted_matrix), 64'd0);
        check("reset_busy", 64'(bus.slave_busy), 64'd0);

        // Single session: master 1 to slave 2, then release.
        req(1, 2);
        tick();
        expect_row("t1_grant", 2, 4'b0010);
        drop(1);
        repeat (3) tick();
        pulse_fin(2);
        check("t1_release", 64'(bus.granted_matrix), 64'd0);
        check("t1_busy", 64'(bus.slave_busy), 64'd0);

        // Contention on slave 0 with wrap-around.
        req(0, 0); req(1, 0); req(3, 0);
        tick();
        expect_row("t2_grant0", 0, t2_seq[0]);
        for (int i = 1; i < 4; i++) begin
            pulse_fin(0);
            expect_row("t2_gap", 0, 4'b0000);
            tick();
            expect_row("t2_grant", 0, t2_seq[i]);
        end
        drop(0); drop(1); drop(3);
        pulse_fin(0);
        tick();

        // Parallel traffic: anti-diagonal permutation.
        req(0, 3); req(1, 2); req(2, 1); req(3, 0);
        tick();
        check("t3_matrix", 64'(bus.granted_matrix), 64'h1248);
        check("t3_busy", 64'(bus.slave_busy), 64'hf);
        for (int m = 0; m < N; m++) drop(m);
        bus.session_is_finished = '1;
        tick();
        bus.session_is_finished = '0;
        check("t3_release", 64'(bus.granted_matrix), 64'd0);

        // Pointer of slave 1 is 3 after the grant to master 2.
        req(3, 1); req(0, 1);
        tick();
        expect_row("t4_first", 1, 4'b1000);
        drop(3);
        pulse_fin(1);
        tick();
        expect_row("t4_second", 1, 4'b0001);
        drop(0);
        pulse_fin(1);

        // Reset mid-session clears grants and pointers.
        req(0, 2);
        tick();
        expect_row("t5_busy", 2, 4'b0001);
        drop(0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_reset_matrix", 64'(bus.granted_matrix), 64'd0);
        check("t5_reset_busy", 64'(bus.slave_busy), 64'd0);
        pulse_fin(2);
        check("t5_spurious_fin", 64'(bus.granted_matrix), 64'd0);
        req(0, 1); req(1, 1);
        tick();
        expect_row("t5_ptr_zero", 1, 4'b0001);
        drop(0); drop(1);
        pulse_fin(1);

        // Address change while busy does not move the grant.
        req(1, 0);
        tick();
        expect_row("t6_grant", 0, 4'b0010);
        bus.master_addr[1] = addr_for(3);
        tick();
        expect_row("t6_hold", 0, 4'b0010);
        expect_row("t6_no_s3", 3, 4'b0000);
        tick();
        pulse_fin(0);
        expect_row("t6_release", 0, 4'b0000);
        expect_row("t6_still_no_s3", 3, 4'b0000);
        tick();
        expect_row("t6_s3", 3, 4'b0010);
        drop(1);
        pulse_fin(3);

        // Random traffic: masters hold requests until granted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < N; m++) begin
                if (bus.master_req[m]) begin
                    if (holds(m)) begin
                        case ($urandom % 8)
                            0: drop(m);
                            1: bus.master_addr[m] = addr_for(int'($urandom % N));
                            default: ;
                        endcase
                    end
                end else if ($urandom % 3 == 0) begin
                    req(m, int'($urandom % N));
                end
            end
            for (int s = 0; s < N; s++)
                bus.session_is_finished[s] = (owner[s] >= 0) ? ($urandom % 4 == 0)
                                                             : ($urandom % 16 == 0);
            rst_n = ($urandom % 400 != 0);
            tick();
        end

        bus.master_req          = '0;
        bus.session_is_finished = '0;
        rst_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("final_reset", 64'(bus.granted_matrix), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
